// File: rtl/trigger_seq_pkg.sv
// Shared state encodings and constants for the multi-stage trigger sequencer.
package trigger_seq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StWait  = 3'd2,
    StDelay = 3'd3,
    StFire  = 3'd4,
    StDone  = 3'd5
  } state_e;

  // Wide enough for any counter width; sliced to CNT_WIDTH at use.
  localparam logic [63:0] TOF_NONE = '1;
  localparam int unsigned Q_SHIFT  = 16;

endpackage

// File: rtl/trigger_ch_cmp.sv
// One sequence stage: picks a channel mean, compares it against the doubled level
// with the chosen polarity, and reports only the false-to-true transition.
module trigger_ch_cmp #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned ADC_DATA_WIDTH = 16,
  parameter int unsigned SEL_WIDTH      = 2
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NUM_CH*(ADC_DATA_WIDTH+1)-1:0]  mean_all,
  input  logic [SEL_WIDTH-1:0]                  sel,
  input  logic                                  pol,
  input  logic [ADC_DATA_WIDTH-1:0]             level,
  output logic                                  hit
);

  localparam int unsigned MW = ADC_DATA_WIDTH + 1;

  logic signed [MW-1:0] mean_sel;
  logic signed [MW-1:0] level_ext;
  logic                 cmp;
  logic                 cmp_q;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    mean_sel = mean_all[0 +: MW];
    for (int n = 1; n < NUM_CH; n++) begin
      if (sel == SEL_WIDTH'(n)) mean_sel = mean_all[n*MW +: MW];
    end
  end

  // Mean is a sum of two samples, so the level is doubled to match.
  assign level_ext = {level, 1'b0};
  assign cmp       = pol ? (mean_sel > level_ext) : (mean_sel < level_ext);
  assign hit       = cmp & ~cmp_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cmp_q <= 1'b0;
    else         cmp_q <= cmp;
  end

endmodule

// File: rtl/trigger_seq_gen.sv
// Multi-stage threshold-crossing sequence trigger with TOF measurement and delayed fire.
// Define TRIG_SEQ_TIMESTAMP_EN to add 48-bit trig/fire timestamp outputs.
module trigger_seq_gen
  import trigger_seq_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned ADC_DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned SEL_WIDTH      = $clog2(NUM_CH)
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [NUM_CH*32-1:0]                 adc_data,
  input  logic [NUM_CH-1:0]                    adc_enable,
  input  logic                                 trig_enable,
  input  logic [NUM_STAGES*SEL_WIDTH-1:0]      stage_sel,
  input  logic [NUM_STAGES-1:0]                stage_pol,
  input  logic [NUM_STAGES*ADC_DATA_WIDTH-1:0] stage_level,
  input  logic [CNT_WIDTH-1:0]                 holdoff,
  input  logic [CNT_WIDTH-1:0]                 timeout,
  input  logic [31:0]                          param_mul,
  input  logic [CNT_WIDTH-1:0]                 param_off,
  input  logic [15:0]                          pulse_len,
  input  logic                                 auto_rearm,
  output logic                                 trigger_out,
  output logic [NUM_STAGES-1:0]                stage_hit,
  output logic [(NUM_STAGES-1)*CNT_WIDTH-1:0]  tof,
  output logic                                 tof_valid,
  output logic                                 timeout_flag,
  output logic [2:0]                           state_o
`ifdef TRIG_SEQ_TIMESTAMP_EN
  ,
  output logic [47:0]                          trig_timestamp,
  output logic [47:0]                          fire_timestamp
`endif
);

  localparam int unsigned MW   = ADC_DATA_WIDTH + 1;
  localparam int unsigned IdxW = $clog2(NUM_STAGES);
  localparam int unsigned PW   = CNT_WIDTH + 32;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [NUM_CH*MW-1:0]   mean_flat;
  logic [NUM_STAGES-1:0]  hit;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   hold_q, hold_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   tof_q [NUM_STAGES-1];
  logic [CNT_WIDTH-1:0]   tof_d [NUM_STAGES-1];
  logic                   tof_valid_q, tof_valid_d;
  logic [NUM_STAGES-1:0]  hit_q, hit_d;
  logic                   tflag_q, tflag_d;
  logic [CNT_WIDTH-1:0]   delay_q, delay_d;
  logic                   dvld_q, dvld_d;
  logic [CNT_WIDTH-1:0]   dcnt_q, dcnt_d;
  logic [15:0]            pcnt_q, pcnt_d;

  logic                   cur_hit;
  logic [15:0]            plen;
  logic [PW-1:0]          prod;
  logic [PW:0]            dsum;
  logic [CNT_WIDTH-1:0]   delay_calc;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_mean
    logic [ADC_DATA_WIDTH-1:0] s0, s1;
    logic [MW-1:0]             mean_q;
    assign s0 = adc_data[32*n +: ADC_DATA_WIDTH];
    assign s1 = adc_data[32*n+16 +: ADC_DATA_WIDTH];
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)            mean_q <= '0;
      else if (adc_enable[n]) mean_q <= {s0[ADC_DATA_WIDTH-1], s0} + {s1[ADC_DATA_WIDTH-1], s1};
    end
    assign mean_flat[n*MW +: MW] = mean_q;
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_cmp
    trigger_ch_cmp #(
      .NUM_CH         (NUM_CH),
      .ADC_DATA_WIDTH (ADC_DATA_WIDTH),
      .SEL_WIDTH      (SEL_WIDTH)
    ) u_cmp (
      .clk      (clk),
      .resetn   (resetn),
      .mean_all (mean_flat),
      .sel      (stage_sel[s*SEL_WIDTH +: SEL_WIDTH]),
      .pol      (stage_pol[s]),
      .level    (stage_level[s*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
      .hit      (hit[s])
    );
  end

  always_comb begin
    cur_hit = 1'b0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (idx_q == IdxW'(k)) cur_hit = hit[k];
    end
  end

  assign plen = (pulse_len == 16'd0) ? 16'd1 : pulse_len;

  // Q16.16 scale of the first TOF plus offset, clamped to the counter range.
  assign prod       = PW'(tof_q[0]) * PW'(param_mul);
  assign dsum       = {1'b0, prod >> Q_SHIFT} + (PW+1)'(param_off);
  assign delay_calc = (dsum > (PW+1)'(CntMax)) ? CntMax : dsum[CNT_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tof_d       = tof_q;
    tof_valid_d = 1'b0;
    hit_d       = hit_q;
    tflag_d     = tflag_q;
    delay_d     = delay_q;
    dvld_d      = dvld_q;
    dcnt_d      = dcnt_q;
    pcnt_d      = pcnt_q;
    case (state_q)
      StIdle: begin
        hit_d = '0;
        if (hold_q == '0) state_d = StArmed;
        else              hold_d  = hold_q - CNT_WIDTH'(1);
      end
      StArmed: begin
        if (hit[0]) begin
          hit_d[0] = 1'b1;
          idx_d    = IdxW'(1);
          cnt_d    = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cur_hit) begin
          for (int k = 1; k < NUM_STAGES; k++) begin
            if (idx_q == IdxW'(k)) begin
              tof_d[k-1] = (cnt_q == CntMax) ? CntMax : cnt_q + CNT_WIDTH'(1);
              hit_d[k]   = 1'b1;
            end
          end
          cnt_d = '0;
          if (idx_q == IdxW'(NUM_STAGES-1)) begin
            tof_valid_d = 1'b1;
            dvld_d      = 1'b0;
            dcnt_d      = '0;
            state_d     = StDelay;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else if (timeout != '0 && cnt_q == timeout - CNT_WIDTH'(1)) begin
          tflag_d = 1'b1;
          hold_d  = holdoff;
          state_d = StIdle;
        end
      end
      StDelay: begin
        // First cycle latches the delay; counting starts the cycle after.
        if (!dvld_q) begin
          delay_d = delay_calc;
          dvld_d  = 1'b1;
        end else if (dcnt_q >= delay_q) begin
          pcnt_d  = '0;
          state_d = StFire;
        end else begin
          dcnt_d = dcnt_q + CNT_WIDTH'(1);
        end
      end
      StFire: begin
        if (pcnt_q >= plen - 16'd1) begin
          if (auto_rearm) begin
            hold_d  = holdoff;
            state_d = StIdle;
          end else begin
            state_d = StDone;
          end
        end else begin
          pcnt_d = pcnt_q + 16'd1;
        end
      end
      StDone: ;
      default: begin
        hold_d  = holdoff;
        state_d = StIdle;
      end
    endcase
    if (!trig_enable) begin
      state_d     = StIdle;
      hold_d      = holdoff;
      hit_d       = '0;
      tflag_d     = 1'b0;
      tof_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      hold_q      <= holdoff;
      idx_q       <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < NUM_STAGES-1; k++) tof_q[k] <= TOF_NONE[CNT_WIDTH-1:0];
      tof_valid_q <= 1'b0;
      hit_q       <= '0;
      tflag_q     <= 1'b0;
      delay_q     <= '0;
      dvld_q      <= 1'b0;
      dcnt_q      <= '0;
      pcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tof_q       <= tof_d;
      tof_valid_q <= tof_valid_d;
      hit_q       <= hit_d;
      tflag_q     <= tflag_d;
      delay_q     <= delay_d;
      dvld_q      <= dvld_d;
      dcnt_q      <= dcnt_d;
      pcnt_q      <= pcnt_d;
    end
  end

  for (genvar k = 0; k < NUM_STAGES-1; k++) begin : g_tof
    assign tof[k*CNT_WIDTH +: CNT_WIDTH] = tof_q[k];
  end

  assign trigger_out  = (state_q == StFire);
  assign stage_hit    = hit_q;
  assign tof_valid    = tof_valid_q;
  assign timeout_flag = tflag_q;
  assign state_o      = state_q;

`ifdef TRIG_SEQ_TIMESTAMP_EN
  logic [47:0] ts_q, trig_ts_q, fire_ts_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts_q      <= '0;
      trig_ts_q <= '0;
      fire_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 48'd1;
      if (!trig_enable) begin
        trig_ts_q <= '0;
        fire_ts_q <= '0;
      end else begin
        if (state_q == StArmed && hit[0])        trig_ts_q <= ts_q;
        if (state_q == StDelay && state_d == StFire) fire_ts_q <= ts_q;
      end
    end
  end

  assign trig_timestamp = trig_ts_q;
  assign fire_timestamp = fire_ts_q;
`endif

endmodule
